// File: rtl/hdmi_video_timing.sv
// hdmi_video_timing
//   Raster timing generator for the HDMI pixel-clock domain. A free-running
//   h/v counter pair is decoded into a registered request stage (req_*), which
//   tells the pixel source which pixel to fetch. A PIPE_DLY-deep shift pipeline
//   then re-times that decode onto de/x/y/hsync/vsync, so the fetched pixel and
//   its timing arrive at the encoder together.
//
// Ports
//   clk_pix      pixel clock
//   srst_n       synchronous active-low reset
//   req_valid    pixel (req_x, req_y) is needed exactly PIPE_DLY cycles from now
//   req_x/req_y  requested coordinate (0 outside active video)
//   de           data enable
//   x/y          coordinate of the current output pixel (0 when de = 0)
//   hsync/vsync  sync outputs, active level set by HS_POL/VS_POL
//   line_start   one-cycle pulse with the first de of each line
//   frame_start  one-cycle pulse with the first de of each frame
module hdmi_video_timing #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int PIPE_DLY = 2,
  parameter int CNT_W    = 12
) (
  input  logic             clk_pix,
  input  logic             srst_n,
  output logic             req_valid,
  output logic [CNT_W-1:0] req_x,
  output logic [CNT_W-1:0] req_y,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             hsync,
  output logic             vsync,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL >= (2 ** CNT_W) || V_TOTAL >= (2 ** CNT_W)) begin : g_bad_total
    $error("hdmi_video_timing: raster totals do not fit in CNT_W bits");
  end
  if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_bad_dly
    $error("hdmi_video_timing: PIPE_DLY must be 1..8");
  end

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_ON  = (HS_POL != 0);
  localparam logic             VS_ON  = (VS_POL != 0);

  typedef struct packed {
    logic             act;
    logic             hs;
    logic             vs;
    logic [CNT_W-1:0] hc;  // already forced to 0 outside active video
    logic [CNT_W-1:0] vc;
  } stage_t;

  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  stage_t           dec;
  stage_t           pipe [PIPE_DLY];  // pipe[0] is the req stage
  stage_t           last;

  always_comb begin
    dec     = '0;
    dec.act = (hcnt < H_ACT) && (vcnt < V_ACT);
    dec.hs  = (hcnt >= HS_BEG) && (hcnt < HS_END);
    // vsync depends on vcnt only, so it naturally switches at hcnt = 0
    dec.vs  = (vcnt >= VS_BEG) && (vcnt < VS_END);
    dec.hc  = dec.act ? hcnt : '0;
    dec.vc  = dec.act ? vcnt : '0;
  end

  assign last = pipe[PIPE_DLY-1];

  always_ff @(posedge clk_pix) begin
    if (!srst_n) begin
      hcnt        <= '0;
      vcnt        <= '0;
      for (int i = 0; i < PIPE_DLY; i++) pipe[i] <= '0;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      hsync       <= !HS_ON;
      vsync       <= !VS_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end

      pipe[0] <= dec;
      for (int i = 1; i < PIPE_DLY; i++) pipe[i] <= pipe[i-1];

      de          <= last.act;
      x           <= last.hc;
      y           <= last.vc;
      hsync       <= last.hs ? HS_ON : !HS_ON;
      vsync       <= last.vs ? VS_ON : !VS_ON;
      line_start  <= last.act && (last.hc == '0);
      frame_start <= last.act && (last.hc == '0) && (last.vc == '0);
    end
  end

  assign req_valid = pipe[0].act;
  assign req_x     = pipe[0].hc;
  assign req_y     = pipe[0].vc;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Testbench for hdmi_video_timing: three instances (720p defaults, a tiny
// active-low raster with PIPE_DLY=1, and a small raster with PIPE_DLY=8).
// A raster model pushes the expected per-cycle outputs into one queue per
// instance; a negedge monitor pops and compares. Directed processes add
// hand-computed timing checks.
module tb_hdmi_video_timing;

  typedef struct packed {
    logic        rv;
    logic [11:0] rx;
    logic [11:0] ry;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } vec_t;

  typedef struct packed {
    int ha, hf, hw, hb, va, vf, vw, vb, hp, vp, pd;
  } cfg_t;

  localparam cfg_t C_DEF  = '{1280, 110, 40, 220, 720, 5, 5, 20, 1, 1, 2};
  localparam cfg_t C_TINY = '{4, 1, 1, 2, 2, 1, 1, 1, 0, 0, 1};
  localparam cfg_t C_MED  = '{16, 2, 3, 4, 6, 1, 2, 2, 1, 1, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_def = 1'b0, rst_tiny = 1'b0, rst_med = 1'b0;

  logic        def_rv, def_de, def_hs, def_vs, def_ls, def_fs;
  logic [11:0] def_rx, def_ry, def_x, def_y;
  logic        tiny_rv, tiny_de, tiny_hs, tiny_vs, tiny_ls, tiny_fs;
  logic [11:0] tiny_rx, tiny_ry, tiny_x, tiny_y;
  logic        med_rv, med_de, med_hs, med_vs, med_ls, med_fs;
  logic [11:0] med_rx, med_ry, med_x, med_y;

  hdmi_video_timing u_def (
    .clk_pix(clk), .srst_n(rst_def),
    .req_valid(def_rv), .req_x(def_rx), .req_y(def_ry),
    .de(def_de), .x(def_x), .y(def_y), .hsync(def_hs), .vsync(def_vs),
    .line_start(def_ls), .frame_start(def_fs)
  );

  hdmi_video_timing #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .PIPE_DLY(1), .CNT_W(12)
  ) u_tiny (
    .clk_pix(clk), .srst_n(rst_tiny),
    .req_valid(tiny_rv), .req_x(tiny_rx), .req_y(tiny_ry),
    .de(tiny_de), .x(tiny_x), .y(tiny_y), .hsync(tiny_hs), .vsync(tiny_vs),
    .line_start(tiny_ls), .frame_start(tiny_fs)
  );

  hdmi_video_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1), .VS_POL(1), .PIPE_DLY(8), .CNT_W(12)
  ) u_med (
    .clk_pix(clk), .srst_n(rst_med),
    .req_valid(med_rv), .req_x(med_rx), .req_y(med_ry),
    .de(med_de), .x(med_x), .y(med_y), .hsync(med_hs), .vsync(med_vs),
    .line_start(med_ls), .frame_start(med_fs)
  );

  vec_t obs_def, obs_tiny, obs_med;
  assign obs_def  = {def_rv, def_rx, def_ry, def_de, def_x, def_y, def_hs, def_vs, def_ls, def_fs};
  assign obs_tiny = {tiny_rv, tiny_rx, tiny_ry, tiny_de, tiny_x, tiny_y, tiny_hs, tiny_vs, tiny_ls, tiny_fs};
  assign obs_med  = {med_rv, med_rx, med_ry, med_de, med_x, med_y, med_hs, med_vs, med_ls, med_fs};

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit run = 1'b0;
  int j_def = 0, j_tiny = 0, j_med = 0;
  vec_t q_def[$], q_tiny[$], q_med[$];

  always @(posedge clk) cyc++;

  // Expected outputs after the edge numbered j (j = 0 is the first edge with reset high)
  function automatic vec_t calc(cfg_t c, int j, bit rst_low);
    vec_t v;
    int ht, vt, hc, vc, p;
    bit act;
    ht = c.ha + c.hf + c.hw + c.hb;
    vt = c.va + c.vf + c.vw + c.vb;
    v = '0;
    v.hs = (c.hp == 0);
    v.vs = (c.vp == 0);
    if (rst_low) return v;
    hc = j % ht;
    vc = (j / ht) % vt;
    act = (hc < c.ha) && (vc < c.va);
    v.rv = act;
    v.rx = act ? 12'(hc) : 12'd0;
    v.ry = act ? 12'(vc) : 12'd0;
    if (j >= c.pd) begin
      p  = j - c.pd;
      hc = p % ht;
      vc = (p / ht) % vt;
      act = (hc < c.ha) && (vc < c.va);
      v.de = act;
      v.x  = act ? 12'(hc) : 12'd0;
      v.y  = act ? 12'(vc) : 12'd0;
      v.hs = ((hc >= c.ha + c.hf) && (hc < c.ha + c.hf + c.hw)) ? (c.hp != 0) : (c.hp == 0);
      v.vs = ((vc >= c.va + c.vf) && (vc < c.va + c.vf + c.vw)) ? (c.vp != 0) : (c.vp == 0);
      v.ls = act && (hc == 0);
      v.fs = act && (hc == 0) && (vc == 0);
    end
    return v;
  endfunction

  // Stimulus side of the scoreboard: reset inputs are driven at negedges, so
  // they are stable here.
  always @(posedge clk) begin
    if (run) begin
      j_def  = rst_def  ? j_def + 1  : 0;
      j_tiny = rst_tiny ? j_tiny + 1 : 0;
      j_med  = rst_med  ? j_med + 1  : 0;
      q_def.push_back(calc(C_DEF, j_def - 1, !rst_def));
      q_tiny.push_back(calc(C_TINY, j_tiny - 1, !rst_tiny));
      q_med.push_back(calc(C_MED, j_med - 1, !rst_med));
    end
  end

  task automatic check_vec(input string name, input vec_t e, input vec_t a);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, a, e);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      if (q_def.size() > 0)  check_vec("sb_def",  q_def.pop_front(),  obs_def);
      if (q_tiny.size() > 0) check_vec("sb_tiny", q_tiny.pop_front(), obs_tiny);
      if (q_med.size() > 0)  check_vec("sb_med",  q_med.pop_front(),  obs_med);
    end
  end

  function automatic bit sig(int which);
    case (which)
      0: return def_rv;
      1: return def_de;
      2: return def_hs;
      3: return tiny_fs;
      default: return 1'b0;
    endcase
  endfunction

  // Waits for the next negedge sample where the selected signal equals level.
  task automatic wait_for(input string name, input int which, input bit level,
                          input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sig(which) == level) begin
        t = cyc;
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL %s timeout after %0d cycles expected level %0d", name, budget, level);
  endtask

  task automatic run_def();
    int t_req, t_de, t_hs, t_hl, t_de2, n;
    wait_for("def_req_rise", 0, 1'b1, 10, t_req);
    wait_for("def_de_rise", 1, 1'b1, 10, t_de);
    check_int("def_req_to_de", t_de - t_req, 2);
    check_int("def_first_fs_ls", {30'd0, def_fs, def_ls}, 3);
    check_int("def_first_xy", {def_x, def_y}, 0);
    n = 1;
    @(negedge clk);
    check_int("def_fs_clear", int'(def_fs), 0);
    while (def_de && n < 3000) begin
      n++;
      @(negedge clk);
    end
    check_int("def_de_width", n, 1280);
    wait_for("def_hs_rise", 2, 1'b1, 300, t_hs);
    check_int("def_de_to_hs", t_hs - t_de, 1390);
    wait_for("def_hs_fall", 2, 1'b0, 100, t_hl);
    check_int("def_hs_width", t_hl - t_hs, 40);
    wait_for("def_de_rise2", 1, 1'b1, 400, t_de2);
    check_int("def_line_period", t_de2 - t_de, 1650);
  endtask

  task automatic run_tiny();
    int t0, n_de, n_fs;
    logic [7:0] de_pat, hs_pat;
    logic [4:0] vs_pat;
    de_pat = '0; hs_pat = '0; vs_pat = '0; n_de = 0; n_fs = 0;
    wait_for("tiny_fs", 3, 1'b1, 10, t0);
    for (int i = 0; i < 40; i++) begin
      if (i < 8) begin
        de_pat = {de_pat[6:0], tiny_de};
        hs_pat = {hs_pat[6:0], !tiny_hs};
      end
      if (i % 8 == 0) vs_pat = {vs_pat[3:0], !tiny_vs};
      n_de += int'(tiny_de);
      n_fs += int'(tiny_fs);
      @(negedge clk);
    end
    check_int("tiny_de_pattern", int'(de_pat), 8'b1111_0000);
    check_int("tiny_hs_low_col", int'(hs_pat), 8'b0000_0100);
    check_int("tiny_vs_low_line", int'(vs_pat), 5'b00010);
    check_int("tiny_de_per_frame", n_de, 8);
    check_int("tiny_fs_per_frame", n_fs, 1);
    check_int("tiny_frame_period", int'(tiny_fs), 1);
  endtask

  task automatic run_med();
    bit found;
    found = 1'b0;
    repeat (560) @(negedge clk);
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (med_de && med_x == 12'd10 && med_y == 12'd3) found = 1'b1;
    end
    check_int("med_reset_point_found", int'(found), 1);
    rst_med = 1'b0;
    repeat (3) @(negedge clk);
    rst_med = 1'b1;
    repeat (600) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    run = 1'b1;
    repeat (4) @(negedge clk);
    rst_def  = 1'b1;
    rst_tiny = 1'b1;
    rst_med  = 1'b1;
    fork
      run_def();
      run_tiny();
      run_med();
    join
    @(negedge clk);
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hdmi_video_timing.md
Name: hdmi_video_timing

Overview:
- Raster timing generator on the pixel clock domain; sits directly downstream of the pixel-clock PLL/reset block and upstream of the pixel source and TMDS encoder/serializer.
- Produces hsync/vsync/de plus pixel coordinates for the HDMI encoder.
- Also produces an early pixel-request strobe, so the pixel source (line buffer/ISP output) can prefetch PIPE_DLY cycles ahead of de.
- Defaults are CEA-861 1280x720p60 at 74.25 MHz.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, hsync width (clocks)
- H_BP, 220, horizontal back porch (clocks)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active-high)
- VS_POL, 1, vsync active level
- PIPE_DLY, 2, cycles from req_* to matching de/x/y (legal 1..8)
- CNT_W, 12, width of h/v counters and coordinate ports

Ports:
- clk_pix  in  1  pixel clock (74.25 MHz default)
- srst_n  in  1  reset, synchronous, active-low
- req_valid  out  1  pixel request: the pixel at (req_x, req_y) is needed in exactly PIPE_DLY cycles
- req_x  out  CNT_W  requested column
- req_y  out  CNT_W  requested row
- de  out  1  data enable (active video)
- x  out  CNT_W  column of current output pixel
- y  out  CNT_W  row of current output pixel
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- line_start  out  1  one-cycle pulse with first de of each active line
- frame_start  out  1  one-cycle pulse with first de of each frame

Behaviour:
- Totals: H_TOTAL = sum of H_* parameters (1650); V_TOTAL = sum of V_* parameters (750).
- Elaboration error if either total ≥ 2^CNT_W or PIPE_DLY is outside 1..8.
- Counters hcnt 0..H_TOTAL-1 and vcnt 0..V_TOTAL-1 advance every clk_pix cycle, with no stall.
  - hcnt wraps at H_TOTAL-1 to 0 and increments vcnt.
  - vcnt wraps at V_TOTAL-1 to 0 on the same edge that hcnt wraps.
- Decode, registered into the req stage:
  - active = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE)
  - hs = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); vsync is whole-line, transitioning at hcnt = 0
- Req stage outputs: req_valid = active; req_x = hcnt and req_y = vcnt when active, else 0.
- Output stage: a PIPE_DLY-deep shift pipeline of {active, hs, vs, hcnt, vcnt} feeds de/x/y/hsync/vsync.
  - All outputs are registered; no combinational path from counters to ports.
  - x and y are 0 when de = 0.
- Latency:
  - Let C0 be the first edge with srst_n sampled 1. req_valid = 1, req_x = 0, req_y = 0 after C0.
  - de = 1, x = 0, y = 0, frame_start = 1 after edge C0+PIPE_DLY.
- Sync polarity: hsync = HS_POL when hs else !HS_POL; vsync likewise with VS_POL.
- line_start = de && x == 0.
- frame_start = de && x == 0 && y == 0.
- Reset (srst_n = 0 sampled at any edge, including mid-frame):
  - Counters go to 0 and every pipeline stage is cleared.
  - req_valid, de, line_start, frame_start = 0; req_x, req_y, x, y = 0.
  - hsync = !HS_POL, vsync = !VS_POL.
  - Outputs stay in this state while srst_n stays low.
  - Restart after release is identical to power-up: no partial frame and no stale pipeline data.
- Steady-state invariants:
  - Exactly H_ACTIVE de-cycles per active line and V_ACTIVE active lines per frame.
  - Frame period = H_TOTAL*V_TOTAL cycles.
  - req_valid(t) == de(t+PIPE_DLY) for all t after reset release.

Test Plan:
- Reset release, defaults:
  - req_valid = 1 with (0,0) one cycle after C0.
  - de = 1, frame_start = 1, line_start = 1 at C0+2; frame_start is 0 thereafter until the next frame.
- Line timing, defaults:
  - de high for 1280 cycles; hsync rises 1390 cycles after de rises and stays high 40 cycles.
  - Next de rise is 1650 cycles after the previous one.
- Frame timing, defaults:
  - vsync high for 5 lines (8250 cycles), rising at the start of line 725.
  - frame_start period is 1,237,500 cycles; de-high count per frame is 921,600; max x = 1279, max y = 719.
- Mid-frame reset: drive srst_n low for 3 cycles at y = 300, x = 500.
  - On the next edge, all outputs are reset values: hsync = 0, vsync = 0, de = 0.
  - After release, the reset-release timing repeats exactly.
- Tiny raster with H 4/1/1/2, V 2/1/1/1, HS_POL = VS_POL = 0, PIPE_DLY = 1:
  - Line period 8; de pattern 11110000.
  - hsync low only at output column index 5; vsync low during line 3 only; frame period 40 cycles.
- PIPE_DLY = 8: scoreboard check that de/x/y equal req_valid/req_x/req_y delayed exactly 8 cycles over 2 full frames.
